normalize_pipe: RTL and testbench

//  Pipelined leading-zero normaliser with valid/ready flow control.

---
 rtl/normalize_pipe_if.sv | 41 ++++
 rtl/normalize_pipe.sv | 140 ++++++++++++++
 tb/tb_normalize_pipe.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/normalize_pipe_if.sv
// ----------------------------------------------------------------------------
// normalize_pipe_if
//   Handshake bundle for normalize_pipe: one upstream valid/ready channel
//   carrying operand, tag and signed-mode flag, and one downstream valid/ready
//   channel carrying the normalised result.
//
//   Upstream   : data_i, tag_i, signed_i, valid_i  -> ready_o
//   Downstream : data_o, norm_o, zero_o, tag_o, valid_o  <- ready_i
//
//   slave  : the normaliser's view
//   master : the view of whoever feeds and drains it
// ----------------------------------------------------------------------------
interface normalize_pipe_if #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 1
);
    localparam int NORM_W = $clog2(WIDTH);

    logic [WIDTH-1:0]  data_i;
    logic [TAG_W-1:0]  tag_i;
    logic              signed_i;
    logic              valid_i;
    logic              ready_o;

    logic [WIDTH-1:0]  data_o;
    logic [NORM_W-1:0] norm_o;
    logic              zero_o;
    logic [TAG_W-1:0]  tag_o;
    logic              valid_o;
    logic              ready_i;

    modport slave (
        input  data_i, tag_i, signed_i, valid_i, ready_i,
        output ready_o, data_o, norm_o, zero_o, tag_o, valid_o
    );

    modport master (
        output data_i, tag_i, signed_i, valid_i, ready_i,
        input  ready_o, data_o, norm_o, zero_o, tag_o, valid_o
    );
endinterface

// File: rtl/normalize_pipe.sv
// ----------------------------------------------------------------------------
// normalize_pipe
//   Pipelined leading-zero normaliser. Each registered stage performs one
//   binary-search level: stage s examines the top K = WIDTH >> (s+1) bits and,
//   when they are redundant, shifts the operand left by K and adds K to the
//   running shift count. Latency is NORM_W = $clog2(WIDTH) cycles.
//
//   Flow control: the whole pipe advances together whenever the output slot
//   is empty or being drained (adv = !valid_o || ready_i); ready_o = adv.
//   Bubbles travel with the pipe rather than being squeezed out.
//
//   Ports
//     clock  : single clock, posedge
//     reset  : synchronous, active-high; flushes every in-flight beat
//     bus    : normalize_pipe_if.slave (operand/tag/signed in, result out)
//
//   Optional feature macro: NORMALIZE_PIPE_SIGNED_EN
//     Defined   - signed_i = 1 selects redundant-sign normalisation: a stage
//                 shifts by K when the top K+1 bits are all equal.
//     Undefined - signed_i is ignored and no signed logic is built.
// ----------------------------------------------------------------------------
module normalize_pipe #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 1
) (
    input logic             clock,
    input logic             reset,
    normalize_pipe_if.slave bus
);
    localparam int NORM_W = $clog2(WIDTH);

    // Per-stage state; index s is the register after binary-search level s.
    logic [WIDTH-1:0]  data_q [NORM_W];
    logic [WIDTH-1:0]  data_d [NORM_W];
    logic [NORM_W-1:0] norm_q [NORM_W];
    logic [NORM_W-1:0] norm_d [NORM_W];
    logic [TAG_W-1:0]  tag_q  [NORM_W];
    logic [TAG_W-1:0]  tag_d  [NORM_W];
    logic [NORM_W-1:0] zero_q, zero_d;
    logic [NORM_W-1:0] vld_q,  vld_d;

    // Operand/count presented to each stage's combinational level.
    logic [WIDTH-1:0]  in_data [NORM_W];
    logic [NORM_W-1:0] in_norm [NORM_W];
    logic              zero_in;
    logic              shift;
    int                k;
    logic              adv;

`ifdef NORMALIZE_PIPE_SIGNED_EN
    localparam logic [WIDTH-1:0] ONES = '1;
    // The final stage never needs the mode bit, so only NORM_W-1 are kept.
    logic [NORM_W-2:0] sgn_q, sgn_d;
    logic [NORM_W-1:0] in_sgn;
    logic [WIDTH-1:0]  top;
`else
    logic unused_signed;
    assign unused_signed = bus.signed_i;
`endif

    assign adv         = !vld_q[NORM_W-1] || bus.ready_i;
    assign bus.ready_o = adv;

    always_comb begin
        // NOTE: every variable gets a value before any branch reads or
        // conditionally overrides it, so no path can infer a latch; blocking
        // assignments are correct here because this is combinational.
        zero_in = (bus.data_i == '0);
`ifdef NORMALIZE_PIPE_SIGNED_EN
        in_sgn  = {sgn_q, bus.signed_i};
        sgn_d   = in_sgn[NORM_W-2:0];
        top     = '0;
        if (bus.signed_i && bus.data_i == ONES) begin
            zero_in = 1'b1;
        end
`endif
        // Sideband bits simply ride one stage further each advance.
        vld_d  = {vld_q[NORM_W-2:0], bus.valid_i};
        zero_d = {zero_q[NORM_W-2:0], zero_in};

        in_data[0] = bus.data_i;
        in_norm[0] = '0;
        tag_d[0]   = bus.tag_i;
        for (int s = 1; s < NORM_W; s++) begin
            in_data[s] = data_q[s-1];
            in_norm[s] = norm_q[s-1];
            tag_d[s]   = tag_q[s-1];
        end

        k     = 0;
        shift = 1'b0;
        for (int s = 0; s < NORM_W; s++) begin
            k     = WIDTH >> (s + 1);
            // Unsigned: top K bits all zero.
            shift = ((in_data[s] >> (WIDTH - k)) == '0);
`ifdef NORMALIZE_PIPE_SIGNED_EN
            // Signed: top K+1 bits all equal, i.e. K redundant sign bits.
            top = in_data[s] >> (WIDTH - k - 1);
            if (in_sgn[s]) begin
                shift = (top == '0) || (top == (ONES >> (WIDTH - k - 1)));
            end
`endif
            data_d[s] = shift ? (in_data[s] << k) : in_data[s];
            norm_d[s] = shift ? (in_norm[s] + k[NORM_W-1:0]) : in_norm[s];
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: reset is tested first so it wins over an advancing pipe; it
        // clears every stage register, not just the valids, so a flushed beat
        // leaves no stale data on the outputs.
        if (reset) begin
            vld_q  <= '0;
            zero_q <= '0;
            for (int s = 0; s < NORM_W; s++) begin
                data_q[s] <= '0;
                norm_q[s] <= '0;
                tag_q[s]  <= '0;
            end
`ifdef NORMALIZE_PIPE_SIGNED_EN
            sgn_q  <= '0;
`endif
        end else if (adv) begin
            vld_q  <= vld_d;
            zero_q <= zero_d;
            data_q <= data_d;
            norm_q <= norm_d;
            tag_q  <= tag_d;
`ifdef NORMALIZE_PIPE_SIGNED_EN
            sgn_q  <= sgn_d;
`endif
        end
    end

    assign bus.data_o  = data_q[NORM_W-1];
    assign bus.norm_o  = norm_q[NORM_W-1];
    assign bus.zero_o  = zero_q[NORM_W-1];
    assign bus.tag_o   = tag_q[NORM_W-1];
    assign bus.valid_o = vld_q[NORM_W-1];
endmodule

// File: tb/tb_normalize_pipe.sv
// ----------------------------------------------------------------------------
// tb_normalize_pipe
//   Scoreboard bench for normalize_pipe (WIDTH=16, TAG_W=4). The driver pushes
//   the expected result when a beat is accepted; an independent monitor
//   compares the queue head against every presented result and pops on
//   ready_i. Signed-mode vectors follow NORMALIZE_PIPE_SIGNED_EN.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_normalize_pipe;
    localparam int WIDTH = 16;
    localparam int TAG_W = 4;
`ifdef NORMALIZE_PIPE_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  norm;
        logic        zero;
        logic [3:0]  tag;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    normalize_pipe_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

    normalize_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int   checks = 0;
    int   errors = 0;
    int   pushed = 0;
    int   popped = 0;
    exp_t exp_q[$];
    bit   rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] d, input logic [3:0] n,
                                input logic z, input logic [3:0] t);
        exp_t e;
        e.data = d;
        e.norm = n;
        e.zero = z;
        e.tag  = t;
        return e;
    endfunction

    // Reference: bit-serial shift loop.
    function automatic exp_t ref_model(input logic [15:0] d, input logic [3:0] t, input logic s);
        exp_t e;
        logic sm;
        int   n;
        sm     = s & SIGNED_EN;
        e.zero = (d == 16'h0000) || (sm && d == 16'hFFFF);
        e.tag  = t;
        n      = 0;
        while (n < 15 && (sm ? (d[15] == d[14]) : !d[15])) begin
            d = d << 1;
            n++;
        end
        e.data = d;
        e.norm = 4'(n);
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [15:0] d, input logic [3:0] t, input logic s, input exp_t e);
        int wait_cnt;
        bit done;
        wait_cnt     = 0;
        done         = 1'b0;
        bus.data_i   = d;
        bus.tag_i    = t;
        bus.signed_i = s;
        bus.valid_i  = 1'b1;
        while (!done) begin
            @(negedge clock);
            if (bus.ready_o && !reset) begin
                exp_q.push_back(e);
                pushed++;
                done = 1'b1;
            end else if (++wait_cnt > 200) begin
                check("send_timeout", 32'd0, 32'd1);
                done = 1'b1;
            end
            @(posedge clock);
            #1;
        end
        bus.valid_i = 1'b0;
    endtask

    task automatic send_ref(input logic [15:0] d, input logic [3:0] t, input logic s);
        send(d, t, s, ref_model(d, t, s));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 500) begin
            @(posedge clock);
            #1;
            c++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: compare every presented result against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset && bus.valid_o) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 32'(bus.valid_o), 32'd0);
                end else begin
                    e = exp_q[0];
                    check("data_o", 32'(bus.data_o), 32'(e.data));
                    check("norm_o", 32'(bus.norm_o), 32'(e.norm));
                    check("zero_o", 32'(bus.zero_o), 32'(e.zero));
                    check("tag_o",  32'(bus.tag_o),  32'(e.tag));
                    if (bus.ready_i) begin
                        void'(exp_q.pop_front());
                        popped++;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (rand_ready) bus.ready_i = 1'($urandom_range(1));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.data_i   = 16'h1234;
        bus.tag_i    = 4'h5;
        bus.signed_i = 1'b0;
        bus.valid_i  = 1'b1;   // offered during reset: must not be taken
        bus.ready_i  = 1'b1;

        // Reset state.
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_valid_o", 32'(bus.valid_o), 32'd0);
        check("rst_data_o",  32'(bus.data_o),  32'd0);
        check("rst_norm_o",  32'(bus.norm_o),  32'd0);
        check("rst_zero_o",  32'(bus.zero_o),  32'd0);
        check("rst_tag_o",   32'(bus.tag_o),   32'd0);
        @(posedge clock);
        #1;
        reset       = 1'b0;
        bus.valid_i = 1'b0;
        @(negedge clock);
        check("post_rst_ready_o", 32'(bus.ready_o), 32'd1);
        @(posedge clock);
        #1;
        idle(6);

        // Hand-computed vectors.
        send(16'h0000, 4'h0, 1'b0, mk(16'h0000, 4'd15, 1'b1, 4'h0));
        send(16'h0001, 4'h1, 1'b0, mk(16'h8000, 4'd15, 1'b0, 4'h1));
        send(16'h8000, 4'h2, 1'b0, mk(16'h8000, 4'd0,  1'b0, 4'h2));
        send(16'h4000, 4'h3, 1'b0, mk(16'h8000, 4'd1,  1'b0, 4'h3));
        send(16'h0003, 4'h4, 1'b0, mk(16'hC000, 4'd14, 1'b0, 4'h4));
        send(16'h00F0, 4'h5, 1'b0, mk(16'hF000, 4'd8,  1'b0, 4'h5));
        send(16'h7FFF, 4'h6, 1'b0, mk(16'hFFFE, 4'd1,  1'b0, 4'h6));
        send(16'h0A00, 4'h7, 1'b0, mk(16'hA000, 4'd4,  1'b0, 4'h7));
        send(16'hFF00, 4'h8, 1'b0, mk(16'hFF00, 4'd0,  1'b0, 4'h8));
`ifdef NORMALIZE_PIPE_SIGNED_EN
        send(16'hFFFF, 4'h9, 1'b1, mk(16'h8000, 4'd15, 1'b1, 4'h9));
        send(16'hFF00, 4'hA, 1'b1, mk(16'h8000, 4'd7,  1'b0, 4'hA));
        send(16'h0100, 4'hB, 1'b1, mk(16'h4000, 4'd6,  1'b0, 4'hB));
        send(16'h0000, 4'hC, 1'b1, mk(16'h0000, 4'd15, 1'b1, 4'hC));
        send(16'hC000, 4'hD, 1'b1, mk(16'h8000, 4'd1,  1'b0, 4'hD));
`else
        send(16'hFFFF, 4'h9, 1'b1, mk(16'hFFFF, 4'd0,  1'b0, 4'h9));
        send(16'h0100, 4'hB, 1'b1, mk(16'h8000, 4'd7,  1'b0, 4'hB));
`endif
        drain();

        // Ramp then random operands, ready held high.
        for (int i = 0; i < 100; i++) send_ref(16'(i), 4'(i), 1'b0);
        for (int i = 0; i < 100; i++) send_ref(16'($urandom), 4'($urandom), 1'b0);
        drain();

        // Back-to-back beats with latency check.
        idle(2);
        send(16'h8000, 4'd1, 1'b0, mk(16'h8000, 4'd0,  1'b0, 4'd1));
        send(16'h4000, 4'd2, 1'b0, mk(16'h8000, 4'd1,  1'b0, 4'd2));
        send(16'h0003, 4'd3, 1'b0, mk(16'hC000, 4'd14, 1'b0, 4'd3));
        @(negedge clock);
        check("lat_not_yet", 32'(bus.valid_o), 32'd0);
        @(negedge clock);
        check("lat_first",   32'(bus.valid_o), 32'd1);
        @(negedge clock);
        check("lat_second",  32'(bus.valid_o), 32'd1);
        @(negedge clock);
        check("lat_third",   32'(bus.valid_o), 32'd1);
        @(negedge clock);
        check("lat_gap",     32'(bus.valid_o), 32'd0);
        @(posedge clock);
        #1;
        drain();

        // Backpressure: fill the pipe, stall 5 cycles with a beat waiting.
        bus.ready_i = 1'b0;
        for (int i = 0; i < 4; i++) send_ref(16'h0010 << i, 4'(8 + i), 1'b0);
        fork
            send_ref(16'h0005, 4'hC, 1'b0);
            begin
                repeat (5) begin
                    @(negedge clock);
                    check("stall_ready_o", 32'(bus.ready_o), 32'd0);
                    check("stall_valid_o", 32'(bus.valid_o), 32'd1);
                end
                @(posedge clock);
                #1;
                bus.ready_i = 1'b1;
            end
        join
        drain();

        // Reset with three beats in flight.
        send_ref(16'h0100, 4'h1, 1'b0);
        send_ref(16'h0200, 4'h2, 1'b0);
        send_ref(16'h0300, 4'h3, 1'b0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        pushed -= exp_q.size();
        exp_q.delete();
        @(negedge clock);
        check("flush_valid_o", 32'(bus.valid_o), 32'd0);
        check("flush_ready_o", 32'(bus.ready_o), 32'd1);
        @(posedge clock);
        #1;
        idle(6);
        send(16'h0020, 4'hE, 1'b0, mk(16'h8000, 4'd10, 1'b0, 4'hE));
        send(16'h0006, 4'hF, 1'b0, mk(16'hC000, 4'd13, 1'b0, 4'hF));
        drain();

        // Random valid and ready, 1000 beats.
        rand_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            while ($urandom_range(1) == 0) idle(1);
            send_ref(16'($urandom), 4'($urandom), 1'($urandom_range(1)));
        end
        rand_ready = 1'b0;
        @(posedge clock);
        #1;
        bus.ready_i = 1'b1;
        drain();

        idle(8);
        check("beats_in_eq_out", 32'(popped), 32'(pushed));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
